// File: rtl/mem_access_stage.sv
// Memory stage: ALU pass-through plus fixed-latency LDB/LDW/STB/STW on a local RAM.
// Optional forwarding outputs bp_data/bp_reg are built when MEM_BYPASS_EN is defined.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int MEM_LAT   = 5,
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  op_in,
  input  logic [31:0] alu_result,
  input  logic [4:0]  dst_in,
  input  logic [9:0]  mem_addr,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst,
  output logic        wb_we,
  output logic        stall,
  output logic        misalign
`ifdef MEM_BYPASS_EN
  ,
  output logic [31:0] bp_data,
  output logic [4:0]  bp_reg
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  localparam logic MULTI = (MEM_LAT > 1);

  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  op_q, op_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_we_q, wb_we_d;
  logic        mis_q, mis_d;

  logic [31:0] mem_q [MEM_WORDS] = '{default: 32'h0};

  logic          busy;
  logic          is_alu_in;
  logic          is_mem_in;
  logic          ok_in;
  logic          go;
  logic [6:0]    acc_op;
  logic [9:0]    acc_addr;
  logic [31:0]   acc_data;
  logic [4:0]    acc_dst;
  logic [AW-1:0] acc_idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  assign busy      = (state_q == BUSY);
  assign is_alu_in = (op_in == 7'h00) || (op_in == 7'h01) || (op_in == 7'h02);
  assign is_mem_in = (op_in >= OP_LDB) && (op_in <= OP_STW);
  assign ok_in     = !((op_in == OP_LDW) || (op_in == OP_STW))
                   || (mem_addr[1:0] == 2'b00);

  // A single-cycle config accesses straight from the inputs.
  assign acc_op   = busy ? op_q   : op_in;
  assign acc_addr = busy ? addr_q : mem_addr;
  assign acc_data = busy ? data_q : alu_result;
  assign acc_dst  = busy ? dst_q  : dst_in;
  assign acc_idx  = acc_addr[AW+1:2];
  assign lane     = acc_addr[1:0];
  assign word     = mem_q[acc_idx];

  assign stall = (!busy && enable && is_mem_in && ok_in && MULTI)
              || (busy && (cnt_q < LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    dst_d     = dst_q;
    wb_data_d = wb_data_q;
    wb_dst_d  = wb_dst_q;
    wb_we_d   = 1'b0;
    mis_d     = 1'b0;
    go        = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = word;

    if (!busy) begin
      if (enable) begin
        if (is_alu_in) begin
          wb_data_d = alu_result;
          wb_dst_d  = dst_in;
          wb_we_d   = 1'b1;
        end else if (is_mem_in && !ok_in) begin
          mis_d = 1'b1;
        end else if (is_mem_in) begin
          if (MULTI) begin
            state_d = BUSY;
            cnt_d   = 4'd1;
            op_d    = op_in;
            addr_d  = mem_addr;
            data_d  = alu_result;
            dst_d   = dst_in;
          end else begin
            go = 1'b1;
          end
        end
      end
    end else if (cnt_q == LAST) begin
      go      = 1'b1;
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    if (go) begin
      unique case (1'b1)
        acc_op == OP_LDW: begin
          wb_data_d = word;
          wb_dst_d  = acc_dst;
          wb_we_d   = 1'b1;
        end
        acc_op == OP_LDB: begin
          wb_data_d = {24'b0, word[{lane, 3'b000} +: 8]};
          wb_dst_d  = acc_dst;
          wb_we_d   = 1'b1;
        end
        acc_op == OP_STW: begin
          mem_we    = 1'b1;
          mem_wdata = acc_data;
        end
        acc_op == OP_STB: begin
          mem_we = 1'b1;
          mem_wdata[{lane, 3'b000} +: 8] = acc_data[7:0];
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_BYPASS_EN
  logic [31:0] bp_data_q, bp_data_d;
  logic [4:0]  bp_reg_q, bp_reg_d;

  always_comb begin
    bp_data_d = wb_data_d;
    bp_reg_d  = (wb_we_d && (wb_dst_d != 5'd0)) ? wb_dst_d : 5'd0;
  end

  assign bp_data = bp_data_q;
  assign bp_reg  = bp_reg_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 7'd0;
      addr_q    <= 10'd0;
      data_q    <= 32'd0;
      dst_q     <= 5'd0;
      wb_data_q <= 32'd0;
      wb_dst_q  <= 5'd0;
      wb_we_q   <= 1'b0;
      mis_q     <= 1'b0;
`ifdef MEM_BYPASS_EN
      bp_data_q <= 32'd0;
      bp_reg_q  <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dst_q     <= dst_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
      wb_we_q   <= wb_we_d;
      mis_q     <= mis_d;
`ifdef MEM_BYPASS_EN
      bp_data_q <= bp_data_d;
      bp_reg_q  <= bp_reg_d;
`endif
    end
  end

  // Reset aborts a pending store before it lands.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[acc_idx] <= mem_wdata;
    end
  end

  assign wb_data  = wb_data_q;
  assign wb_dst   = wb_dst_q;
  assign wb_we    = wb_we_q;
  assign misalign = mis_q;

endmodule
